inst_fetch_queue: RTL

//  Instruction fetch stage upstream of the single-cycle core top. Owns the fetch PC, issues

---
 rtl/inst_fetch_queue_if.sv | 46 ++++
 rtl/inst_fetch_queue.sv | 124 ++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response channel and the
// instr/pc handshake towards the core. The fetch queue is the master, memory/core the slave.
interface inst_fetch_queue_if;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;

    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;

    modport master (
        input  redirect_valid,
        input  redirect_pc,
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_resp_valid,
        input  imem_resp_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    modport slave (
        output redirect_valid,
        output redirect_pc,
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_resp_valid,
        output imem_resp_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch, in-order response buffering with
// PCs, and redirect flush that silently drops responses to requests issued before the redirect.
module inst_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    inst_fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   resp_pc_q, resp_pc_d;

    logic [CW:0]   credit_used;
    logic          can_issue;
    logic          redirect;
    logic          req_fire;
    logic          resp_seen;
    logic          push;
    logic          pop;
    logic [63:0]   redirect_base;

    assign redirect      = bus.redirect_valid;
    assign redirect_base = {bus.redirect_pc[63:2], 2'b00};

    // Buffered entries plus outstanding requests bound the FIFO, so a response always fits.
    assign credit_used = {1'b0, occ_q} + {1'b0, inflight_q};
    assign can_issue   = credit_used < (CW+1)'(DEPTH);

    // Held low while reset is asserted so no request leaks out during reset.
    assign bus.imem_req_valid = can_issue & ~redirect & rst;
    assign bus.imem_req_addr  = fetch_pc_q;

    assign req_fire  = bus.imem_req_valid & bus.imem_req_ready;
    assign resp_seen = bus.imem_resp_valid & (inflight_q != '0);
    assign push      = resp_seen & (drop_q == '0) & ~redirect;
    assign pop       = bus.out_valid & bus.out_ready & ~redirect;

    assign bus.out_valid = (occ_q != '0);
    assign bus.out_instr = mem_q[rd_ptr_q].instr;
    assign bus.out_pc    = mem_q[rd_ptr_q].pc;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        mem_d      = mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        occ_d      = occ_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;

        if (redirect) begin
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            occ_d      = '0;
            // Every request still outstanding belongs to the old path; drop is a subset of
            // inflight, so it is re-derived from inflight rather than added to.
            inflight_d = inflight_q - CW'(resp_seen);
            drop_d     = inflight_q - CW'(resp_seen);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end
            inflight_d = inflight_q + CW'(req_fire) - CW'(resp_seen);
            if (resp_seen && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: resp_pc_q, instr: bus.imem_resp_data};
                wr_ptr_d        = wr_ptr_q + 1'b1;
                resp_pc_d       = resp_pc_q + 64'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the storage array is reset too, so the head fields read zero after reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            occ_q      <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
        end
    end
endmodule
